// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            FSM state encoding, error codes, latency-counter width.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic DMEM_ERR_NONE = 1'b0;
    localparam logic DMEM_ERR_ADDR = 1'b1;

    // Largest supported LATENCY and the counter width needed to hold it
    localparam int DMEM_LAT_MAX = 15;
    localparam int DMEM_CNT_W   = $clog2(DMEM_LAT_MAX + 1);

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Request/response handshake bundle of the CPU data-memory port.
//            master = requester (core), slave = responder (memory).
// Revision : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Word storage for the data-memory responder. Preloads from
//            init_values while reset is high, one byte-enabled write port,
//            one combinational read port, full contents exported.
// Revision : 1.0  initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic [DEPTH-1:0][31:0]  init_values,
    input  wire logic                    wr_en,
    input  wire logic [AW-1:0]           addr,
    input  wire logic [31:0]             wr_data,
    input  wire logic [3:0]              wr_strb,
    output logic      [31:0]             rd_data,
    output logic      [DEPTH-1:0][31:0]  mem_check
);

    logic [DEPTH-1:0][31:0] r_mem;

    // Reset reloads the whole array; otherwise write the enabled bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= init_values;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    r_mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data   = r_mem[addr];
    assign mem_check = r_mem;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Responder side of the CPU data-memory port. Accepts one
//            load/store at a time, performs it on dmem_array and returns a
//            response LATENCY cycles later, held until rsp_ready.
//            Optional macro DMEM_BYTE_STRB_EN: honour req_wstrb on stores
//            (default: every valid store writes the full word).
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    data_mem_responder_if.slave          bus,
    input  wire logic [DEPTH-1:0][31:0]  init_values,
    output logic      [DEPTH-1:0][31:0]  mem_check
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_t           r_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic [29:0]           w_word_idx;
    logic                  w_addr_err;
    logic                  w_accept;
    logic                  w_store;
    logic [3:0]            w_strb;
    logic [31:0]           w_rd_word;

    assign w_word_idx = bus.req_addr[31:2];
    assign w_addr_err = (bus.req_addr[1:0] != 2'b00) || (w_word_idx >= 30'(DEPTH));
    assign w_accept   = bus.req_valid && r_req_ready;
    assign w_store    = w_accept && bus.req_write && !w_addr_err;

`ifdef DMEM_BYTE_STRB_EN
    assign w_strb = bus.req_wstrb;
`else
    // Strobes are ignored in this build: every valid store writes all bytes
    assign w_strb = 4'hF;
    wire unused_strb = &{1'b0, bus.req_wstrb};
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .init_values (init_values),
        .wr_en       (w_store),
        .addr        (w_word_idx[AW-1:0]),
        .wr_data     (bus.req_wdata),
        .wr_strb     (w_strb),
        .rd_data     (w_rd_word),
        .mem_check   (mem_check)
    );

    // Request/response FSM with latency counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= DMEM_ERR_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_addr_err) begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= DMEM_ERR_ADDR;
                        end else begin
                            r_rsp_rdata <= bus.req_write ? 32'd0 : w_rd_word;
                            r_rsp_err   <= DMEM_ERR_NONE;
                        end
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= DMEM_CNT_W'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - DMEM_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= DMEM_ERR_NONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
